// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input front end: joystick bit
// positions, PS/2 scancodes, rotation modes and credit-sequencer states.
package arcade_input_pkg;

   localparam int JB_RIGHT = 0;
   localparam int JB_LEFT  = 1;
   localparam int JB_DOWN  = 2;
   localparam int JB_UP    = 3;
   localparam int JB_FIRE  = 4;
   localparam int JB_BOMB  = 5;
   localparam int JB_START = 6;
   localparam int JB_COIN  = 7;

   // Direction keys compare only the low byte so arrow and keypad codes both hit.
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   localparam logic [8:0] SC_FIRE  = 9'h014;
   localparam logic [8:0] SC_BOMB  = 9'h029;
   localparam logic [8:0] SC_COIN  = 9'h003;

   typedef enum logic [1:0] {
      ROT_0   = 2'd0,
      ROT_90  = 2'd1,
      ROT_180 = 2'd2,
      ROT_270 = 2'd3
   } rot_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COIN  = 2'd1,
      ST_GAP   = 2'd2,
      ST_START = 2'd3
   } seq_state_e;

   function automatic logic [8:0] start_code(input int p);
      case (p)
         0:       return 9'h005;
         1:       return 9'h006;
         2:       return 9'h004;
         default: return 9'h00C;
      endcase
   endfunction

endpackage

// File: rtl/credit_sequencer.sv
// Coin / gap / start pulse generator triggered by a rising start edge.
// Outputs are next-state decodes so the parent register lands them 1 cycle after the edge.
module credit_sequencer
   import arcade_input_pkg::*;
#(
   parameter int PLAYERS      = 2,
   parameter int COIN_CYCLES  = 960000,
   parameter int GAP_CYCLES   = 2400000,
   parameter int START_CYCLES = 960000
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic [PLAYERS-1:0] raw_start,
   output logic               seq_coin,
   output logic [PLAYERS-1:0] seq_start,
   output logic               seq_busy
);

   localparam int MAX_CYC = (COIN_CYCLES > GAP_CYCLES) ?
                            ((COIN_CYCLES > START_CYCLES) ? COIN_CYCLES : START_CYCLES) :
                            ((GAP_CYCLES > START_CYCLES) ? GAP_CYCLES : START_CYCLES);
   localparam int CW = $clog2(MAX_CYC + 1);
   localparam int IW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;

   seq_state_e        state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [IW-1:0]     idx, idx_nxt;
   logic [PLAYERS-1:0] start_q;
   logic [PLAYERS-1:0] rise;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         idx     <= '0;
         start_q <= raw_start;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         idx     <= idx_nxt;
         start_q <= raw_start;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      rise      = raw_start & ~start_q;
      case (state)
         ST_IDLE: begin
            if (|rise) begin
               state_nxt = ST_COIN;
               cnt_nxt   = CW'(COIN_CYCLES - 1);
               // Walk downward so the lowest simultaneous index wins.
               for (int p = PLAYERS - 1; p >= 0; p--) begin
                  if (rise[p]) idx_nxt = IW'(p);
               end
            end
         end
         ST_COIN: begin
            if (cnt == '0) begin
               state_nxt = ST_GAP;
               cnt_nxt   = CW'(GAP_CYCLES - 1);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         ST_GAP: begin
            if (cnt == '0) begin
               state_nxt = ST_START;
               cnt_nxt   = CW'(START_CYCLES - 1);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         ST_START: begin
            if (cnt == '0) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase

      seq_coin = (state_nxt == ST_COIN);
      seq_busy = (state_nxt != ST_IDLE);
      seq_start = '0;
      for (int p = 0; p < PLAYERS; p++) begin
         seq_start[p] = (state_nxt == ST_START) && (idx_nxt == IW'(p));
      end
   end

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keys and joysticks, rotates directions; joystick/rot->out 1 cycle, ps2->out 2 cycles.
// ARCADE_AUTO_COIN_EN builds the credit sequencer; otherwise starts/coin pass straight through.
module arcade_input_mapper
   import arcade_input_pkg::*;
#(
   parameter int PLAYERS      = 2,
   parameter int COIN_CYCLES  = 960000,
   parameter int GAP_CYCLES   = 2400000,
   parameter int START_CYCLES = 960000
) (
   input  logic                    clk_sys,
   input  logic                    reset,
   input  logic [10:0]             ps2_key,
   input  logic [16*PLAYERS-1:0]   joystick,
   input  logic [1:0]              rot,
   output logic [PLAYERS-1:0]      o_up,
   output logic [PLAYERS-1:0]      o_down,
   output logic [PLAYERS-1:0]      o_left,
   output logic [PLAYERS-1:0]      o_right,
   output logic [PLAYERS-1:0]      o_fire,
   output logic [PLAYERS-1:0]      o_bomb,
   output logic [PLAYERS-1:0]      o_start,
   output logic                    o_coin,
   output logic                    o_busy
);

   logic               tog_q;
   logic               key_evt;
   logic               pressed;
   logic [8:0]         code;

   logic               kb_up, kb_down, kb_left, kb_right;
   logic               kb_fire, kb_bomb, kb_coin;
   logic [PLAYERS-1:0] kb_start;

   logic [PLAYERS-1:0] raw_up, raw_down, raw_left, raw_right;
   logic [PLAYERS-1:0] raw_fire, raw_bomb, raw_start;
   logic [PLAYERS-1:0] rot_up, rot_down, rot_left, rot_right;
   logic               man_coin;
   logic               unused_bits;

   assign key_evt = ps2_key[10] ^ tog_q;
   assign pressed = ps2_key[9];
   assign code    = ps2_key[8:0];

   // Toggle copy follows the input even in reset so no phantom event appears afterwards.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         tog_q    <= ps2_key[10];
         kb_up    <= 1'b0;
         kb_down  <= 1'b0;
         kb_left  <= 1'b0;
         kb_right <= 1'b0;
         kb_fire  <= 1'b0;
         kb_bomb  <= 1'b0;
         kb_coin  <= 1'b0;
         kb_start <= '0;
      end else begin
         tog_q <= ps2_key[10];
         if (key_evt) begin
            if (code[7:0] == SC_UP)    kb_up    <= pressed;
            if (code[7:0] == SC_DOWN)  kb_down  <= pressed;
            if (code[7:0] == SC_LEFT)  kb_left  <= pressed;
            if (code[7:0] == SC_RIGHT) kb_right <= pressed;
            if (code == SC_FIRE)       kb_fire  <= pressed;
            if (code == SC_BOMB)       kb_bomb  <= pressed;
            if (code == SC_COIN)       kb_coin  <= pressed;
            for (int p = 0; p < PLAYERS; p++) begin
               if (code == start_code(p)) kb_start[p] <= pressed;
            end
         end
      end
   end

   always_comb begin
      raw_up      = '0;
      raw_down    = '0;
      raw_left    = '0;
      raw_right   = '0;
      raw_fire    = '0;
      raw_bomb    = '0;
      raw_start   = '0;
      man_coin    = kb_coin;
      unused_bits = 1'b0;
      for (int p = 0; p < PLAYERS; p++) begin
         raw_right[p] = joystick[16*p + JB_RIGHT];
         raw_left[p]  = joystick[16*p + JB_LEFT];
         raw_down[p]  = joystick[16*p + JB_DOWN];
         raw_up[p]    = joystick[16*p + JB_UP];
         raw_fire[p]  = joystick[16*p + JB_FIRE];
         raw_bomb[p]  = joystick[16*p + JB_BOMB];
         raw_start[p] = joystick[16*p + JB_START] | kb_start[p];
         man_coin     = man_coin | joystick[16*p + JB_COIN];
         unused_bits  = unused_bits ^ (^joystick[16*p + 8 +: 8]);
      end
      raw_up[0]    = raw_up[0]    | kb_up;
      raw_down[0]  = raw_down[0]  | kb_down;
      raw_left[0]  = raw_left[0]  | kb_left;
      raw_right[0] = raw_right[0] | kb_right;
      raw_fire[0]  = raw_fire[0]  | kb_fire;
      raw_bomb[0]  = raw_bomb[0]  | kb_bomb;
   end

   always_comb begin
      rot_up    = raw_up;
      rot_down  = raw_down;
      rot_left  = raw_left;
      rot_right = raw_right;
      case (rot_e'(rot))
         ROT_90: begin
            rot_up    = raw_left;
            rot_down  = raw_right;
            rot_left  = raw_down;
            rot_right = raw_up;
         end
         ROT_180: begin
            rot_up    = raw_down;
            rot_down  = raw_up;
            rot_left  = raw_right;
            rot_right = raw_left;
         end
         ROT_270: begin
            rot_up    = raw_right;
            rot_down  = raw_left;
            rot_left  = raw_up;
            rot_right = raw_down;
         end
         default: ;
      endcase
   end

`ifdef ARCADE_AUTO_COIN_EN
   logic               seq_coin;
   logic [PLAYERS-1:0] seq_start;
   logic               seq_busy;

   credit_sequencer #(
      .PLAYERS      (PLAYERS),
      .COIN_CYCLES  (COIN_CYCLES),
      .GAP_CYCLES   (GAP_CYCLES),
      .START_CYCLES (START_CYCLES)
   ) u_credit_sequencer (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .raw_start (raw_start),
      .seq_coin  (seq_coin),
      .seq_start (seq_start),
      .seq_busy  (seq_busy)
   );
`else
   localparam int unused_cycles = COIN_CYCLES + GAP_CYCLES + START_CYCLES;
   assign o_busy = 1'b0;
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         o_up    <= '0;
         o_down  <= '0;
         o_left  <= '0;
         o_right <= '0;
         o_fire  <= '0;
         o_bomb  <= '0;
         o_start <= '0;
         o_coin  <= 1'b0;
`ifdef ARCADE_AUTO_COIN_EN
         o_busy  <= 1'b0;
`endif
      end else begin
         o_up    <= rot_up;
         o_down  <= rot_down;
         o_left  <= rot_left;
         o_right <= rot_right;
         o_fire  <= raw_fire;
         o_bomb  <= raw_bomb;
`ifdef ARCADE_AUTO_COIN_EN
         o_start <= seq_start;
         o_coin  <= seq_coin | man_coin;
         o_busy  <= seq_busy;
`else
         o_start <= raw_start;
         o_coin  <= man_coin;
`endif
      end
   end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper (PLAYERS=2, COIN=4, GAP=3, START=5).
module tb_arcade_input_mapper;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic [31:0] joystick;
   logic [1:0]  rot;
   logic [1:0]  o_up, o_down, o_left, o_right, o_fire, o_bomb, o_start;
   logic        o_coin, o_busy;

   int checks = 0;
   int errors = 0;

   arcade_input_mapper #(
      .PLAYERS      (2),
      .COIN_CYCLES  (4),
      .GAP_CYCLES   (3),
      .START_CYCLES (5)
   ) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .ps2_key  (ps2_key),
      .joystick (joystick),
      .rot      (rot),
      .o_up     (o_up),
      .o_down   (o_down),
      .o_left   (o_left),
      .o_right  (o_right),
      .o_fire   (o_fire),
      .o_bomb   (o_bomb),
      .o_start  (o_start),
      .o_coin   (o_coin),
      .o_busy   (o_busy)
   );

   always #5 clk_sys = ~clk_sys;

   logic [12:0] io_bus;
   assign io_bus = {o_up, o_down, o_left, o_right, o_fire, o_bomb, o_coin};

   typedef struct {
      string       name;
      logic [1:0]  rot;
      logic [31:0] js;
      logic [12:0] exp;
   } vec_t;

   vec_t vecs[13];

   function automatic logic [12:0] mk(input logic [1:0] u, input logic [1:0] d,
                                      input logic [1:0] l, input logic [1:0] r,
                                      input logic [1:0] f, input logic [1:0] b,
                                      input logic c);
      return {u, d, l, r, f, b, c};
   endfunction

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic key(input logic [8:0] code, input logic pressed);
      ps2_key = {~ps2_key[10], pressed, code};
   endtask

`ifdef ARCADE_AUTO_COIN_EN
   // Caller has already put a start edge on the inputs; this walks all 13 cycles.
   task automatic run_sequence(input string tag, input logic [1:0] exp_start, input bit inject_gap);
      logic [3:0] exp;
      for (int i = 1; i <= 13; i++) begin
         tick();
         if (i == 1) joystick = '0;
         if (inject_gap && i == 5) joystick = 32'h0040_0000;
         if (inject_gap && i == 6) joystick = '0;
         if (i <= 4)       exp = {1'b1, 2'b00, 1'b1};
         else if (i <= 7)  exp = {1'b0, 2'b00, 1'b1};
         else if (i <= 12) exp = {1'b0, exp_start, 1'b1};
         else              exp = 4'b0000;
         check($sformatf("%s cyc%0d coin/start/busy", tag, i), {28'd0, o_coin, o_start, o_busy}, {28'd0, exp});
      end
   endtask
`endif

   initial begin
      vecs[0]  = '{"idle",          2'd0, 32'h0000_0000, mk(2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0)};
      vecs[1]  = '{"r0 p0 up",      2'd0, 32'h0000_0008, mk(2'b01,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0)};
      vecs[2]  = '{"r1 p1 left",    2'd1, 32'h0002_0000, mk(2'b10,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0)};
      vecs[3]  = '{"r3 p1 left",    2'd3, 32'h0002_0000, mk(2'b00,2'b10,2'b00,2'b00,2'b00,2'b00,1'b0)};
      vecs[4]  = '{"r2 p0 up",      2'd2, 32'h0000_0008, mk(2'b00,2'b01,2'b00,2'b00,2'b00,2'b00,1'b0)};
      vecs[5]  = '{"r1 p0 right",   2'd1, 32'h0000_0001, mk(2'b00,2'b01,2'b00,2'b00,2'b00,2'b00,1'b0)};
      vecs[6]  = '{"r3 p0 down",    2'd3, 32'h0000_0004, mk(2'b00,2'b00,2'b00,2'b01,2'b00,2'b00,1'b0)};
      vecs[7]  = '{"r1 p1 up",      2'd1, 32'h0008_0000, mk(2'b00,2'b00,2'b00,2'b10,2'b00,2'b00,1'b0)};
      vecs[8]  = '{"fire bomb",     2'd0, 32'h0020_0010, mk(2'b00,2'b00,2'b00,2'b00,2'b01,2'b10,1'b0)};
      vecs[9]  = '{"r2 p0 up+left", 2'd2, 32'h0000_000A, mk(2'b00,2'b01,2'b00,2'b01,2'b00,2'b00,1'b0)};
      vecs[10] = '{"p1 coin",       2'd0, 32'h0080_0000, mk(2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1)};
      vecs[11] = '{"high bits",     2'd0, 32'hFF00_FF00, mk(2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0)};
      vecs[12] = '{"r3 mix",        2'd3, 32'h0008_0001, mk(2'b01,2'b00,2'b10,2'b00,2'b00,2'b00,1'b0)};

      reset    = 1'b1;
      ps2_key  = '0;
      joystick = '0;
      rot      = 2'd0;
      tick();
      tick();
      check("reset outputs", {17'd0, io_bus, o_start}, 32'd0);
      check("reset busy", {31'd0, o_busy}, 32'd0);
      reset = 1'b0;
      tick();

      foreach (vecs[i]) begin
         rot      = vecs[i].rot;
         joystick = vecs[i].js;
         tick();
         check(vecs[i].name, {19'd0, io_bus}, {19'd0, vecs[i].exp});
      end
      rot      = 2'd0;
      joystick = '0;
      tick();

      // Keyboard path: two-cycle latency, extended arrow code drives player 0.
      key(9'h175, 1'b1);
      tick();
      check("kbd up +1", {30'd0, o_up}, 32'd0);
      tick();
      check("kbd up +2", {30'd0, o_up}, 32'd1);
      key(9'h175, 1'b0);
      tick();
      check("kbd up rel +1", {30'd0, o_up}, 32'd1);
      tick();
      check("kbd up rel +2", {30'd0, o_up}, 32'd0);

      key(9'h015, 1'b1);
      tick();
      tick();
      check("kbd unmapped", {17'd0, io_bus, o_start}, 32'd0);
      key(9'h015, 1'b0);
      tick();

      key(9'h003, 1'b1);
      tick();
      tick();
      check("kbd F5 coin", {31'd0, o_coin}, 32'd1);
      key(9'h003, 1'b0);
      tick();
      tick();
      check("kbd F5 release", {31'd0, o_coin}, 32'd0);

      key(9'h004, 1'b1);
      tick();
      tick();
      check("start2 ignored", {29'd0, o_start, o_busy}, 32'd0);
      key(9'h004, 1'b0);
      tick();
      tick();

`ifdef ARCADE_AUTO_COIN_EN
      joystick = 32'h0040_0000;
      run_sequence("p1 seq", 2'b10, 1'b0);

      joystick = 32'h0040_0040;
      run_sequence("dual seq", 2'b01, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("no retrigger %0d", i), {29'd0, o_coin, o_start, o_busy}, 32'd0);
      end

      joystick = 32'h0000_0040;
      tick();
      check("pre-reset coin", {31'd0, o_coin}, 32'd1);
      tick();
      reset = 1'b1;
      tick();
      check("mid reset outputs", {17'd0, io_bus, o_start}, 32'd0);
      check("mid reset busy", {31'd0, o_busy}, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         check($sformatf("held start %0d", i), {29'd0, o_coin, o_start, o_busy}, 32'd0);
      end
      joystick = '0;
      tick();
`else
      key(9'h006, 1'b1);
      tick();
      tick();
      check("F2 start", {30'd0, o_start}, 32'd2);
      tick();
      check("F2 held", {29'd0, o_start, o_busy}, 32'd4);
      key(9'h006, 1'b0);
      tick();
      tick();
      check("F2 release", {30'd0, o_start}, 32'd0);

      joystick = 32'h0000_0040;
      tick();
      check("js p0 start", {29'd0, o_start, o_busy}, 32'd2);
      joystick = 32'h0000_0080;
      tick();
      check("js coin no busy", {29'd0, o_start, o_coin, o_busy}, 32'd2);
      joystick = '0;
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
